// File: rtl/clkdiv_gen.sv
// Multi-channel programmable clock divider: registered, glitch-free divided
// clocks with per-channel run enable and period-aligned ratio updates.
module clkdiv_gen #(
  parameter int NCH      = 2,
  parameter int DIVW     = 8,
  parameter int DIV_INIT = 5
) (
  input  logic            fclk,
  input  logic            rst,
  input  logic [NCH-1:0]  en,
  input  logic [NCH-1:0]  div_wr,
  input  logic [DIVW-1:0] div_val,
  output logic [NCH-1:0]  clk_out,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [DIVW-1:0] DIV_RST = DIVW'(DIV_INIT);

  if (DIV_INIT < 2 || DIV_INIT > (1 << DIVW) - 1) begin : g_bad_init
    $error("clkdiv_gen: DIV_INIT outside 2..2^DIVW-1");
  end

  logic div_ok;
  assign div_ok = (div_val >= DIVW'(2));

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t          state_reg, state_next;
    logic [DIVW-1:0] cnt_reg, cnt_next;
    logic [DIVW-1:0] div_reg, div_next;
    logic [DIVW-1:0] pdiv_reg, pdiv_next;
    logic            busy_reg, busy_next;
    logic            clk_reg, clk_next;
    logic            tick_reg, tick_next;
    logic            wrap, apply;

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      wrap       = (state_reg != IDLE) && (cnt_reg == div_reg - DIVW'(1));

      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (en[gi]) state_next = RUN;
        end
        RUN: begin
          cnt_next = wrap ? '0 : cnt_reg + DIVW'(1);
          // Dropping en on the last cycle of a period means that period is already complete.
          if (!en[gi]) state_next = wrap ? IDLE : STOP;
        end
        STOP: begin
          cnt_next = wrap ? '0 : cnt_reg + DIVW'(1);
          if (wrap) state_next = en[gi] ? RUN : IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase

      // Ratio changes land only on a period boundary, or immediately when idle.
      apply     = busy_reg && ((state_reg == IDLE) || wrap);
      div_next  = apply ? pdiv_reg : div_reg;
      pdiv_next = pdiv_reg;
      busy_next = busy_reg && !apply;
      if (div_wr[gi] && div_ok) begin
        pdiv_next = div_val;
        busy_next = 1'b1;
      end

      clk_next  = (state_next != IDLE) && (cnt_next < (div_next >> 1));
      tick_next = (state_next == RUN) && (cnt_next == '0);
    end

    always_ff @(posedge fclk) begin
      if (rst) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        div_reg   <= DIV_RST;
        pdiv_reg  <= DIV_RST;
        busy_reg  <= 1'b0;
        clk_reg   <= 1'b0;
        tick_reg  <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        div_reg   <= div_next;
        pdiv_reg  <= pdiv_next;
        busy_reg  <= busy_next;
        clk_reg   <= clk_next;
        tick_reg  <= tick_next;
      end
    end

    assign clk_out[gi] = clk_reg;
    assign tick[gi]    = tick_reg;
    assign busy[gi]    = busy_reg;
  end

endmodule

// File: tb/tb_clkdiv_gen.sv
// Directed bench for clkdiv_gen: reset, default ratio, ratio updates, stop/restart,
// reset mid-high-phase and two independent channels.
module tb_clkdiv_gen;
  logic       fclk = 1'b0;
  logic       rst;
  logic [1:0] en;
  logic [1:0] div_wr;
  logic [7:0] div_val;
  logic [1:0] clk_out;
  logic [1:0] tick;
  logic [1:0] busy;

  int total  = 0;
  int passed = 0;

  clkdiv_gen #(.NCH(2), .DIVW(8), .DIV_INIT(5)) dut (
    .fclk(fclk), .rst(rst), .en(en), .div_wr(div_wr), .div_val(div_val),
    .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  always #5 fclk = ~fclk;

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("chk %-10s obs=%0d exp=%0d ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 2'b00; div_wr = 2'b00; div_val = 8'd0;
    step(); step();
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();
    chk("idle_clk", int'(clk_out), 0);

    // Illegal ratios are ignored
    div_val = 8'd1; div_wr = 2'b01; step(); div_wr = 2'b00;
    chk("ill1_busy", int'(busy[0]), 0);
    div_val = 8'd0; div_wr = 2'b01; step(); div_wr = 2'b00;
    chk("ill0_busy", int'(busy[0]), 0);

    // Default ratio 5: 1,1,0,0,0 with tick on cnt 0
    en = 2'b01;
    for (int k = 0; k < 11; k++) begin
      step();
      chk("d5_clk", int'(clk_out[0]), int'((k % 5) < 2));
      chk("d5_tick", int'(tick[0]), int'((k % 5) == 0));
    end
    // Now at cnt=0; write 4 so busy covers cnt 1..4
    div_val = 8'd4; div_wr = 2'b01;
    for (int k = 1; k < 5; k++) begin
      step(); div_wr = 2'b00;
      chk("w4_busy", int'(busy[0]), 1);
      chk("w4_clk", int'(clk_out[0]), int'(k < 2));
    end
    for (int k = 0; k < 8; k++) begin
      step();
      chk("d4_clk", int'(clk_out[0]), int'((k % 4) < 2));
      chk("d4_tick", int'(tick[0]), int'((k % 4) == 0));
      chk("d4_busy", int'(busy[0]), 0);
    end

    // Write at wrap, then overwrite twice while pending; last value (5) wins
    div_val = 8'd5; div_wr = 2'b01; step();
    chk("wrap_busy", int'(busy[0]), 1);
    chk("wrap_clk", int'(clk_out[0]), 1);
    div_val = 8'd7; step();
    chk("ovr1_busy", int'(busy[0]), 1);
    div_val = 8'd5; step(); div_wr = 2'b00;
    chk("ovr2_busy", int'(busy[0]), 1);
    step();
    chk("ovr3_busy", int'(busy[0]), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("r5_clk", int'(clk_out[0]), int'(k < 2));
      chk("r5_busy", int'(busy[0]), 0);
    end

    // Stop at cnt=1: period completes, then idles low
    step();
    chk("st0_tick", int'(tick[0]), 1);
    en = 2'b00;
    for (int k = 1; k < 8; k++) begin
      step();
      chk("stop_clk", int'(clk_out[0]), int'(k == 1));
      chk("stop_tick", int'(tick[0]), 0);
    end
    en = 2'b01;
    step();
    chk("re_clk", int'(clk_out[0]), 1);
    chk("re_tick", int'(tick[0]), 1);
    step();
    chk("re1_clk", int'(clk_out[0]), 1);

    // Reset mid-high-phase, overriding a concurrent write
    rst = 1'b1; div_val = 8'd9; div_wr = 2'b01; step();
    rst = 1'b0; div_wr = 2'b00;
    chk("mrst_clk", int'(clk_out), 0);
    chk("mrst_tick", int'(tick), 0);
    chk("mrst_busy", int'(busy), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("pr_clk", int'(clk_out[0]), int'(k < 2));
      chk("pr_tick", int'(tick[0]), int'(k == 0));
    end

    // Two channels: ch0 ratio 2, ch1 ratio 3
    rst = 1'b1; en = 2'b00; step(); rst = 1'b0;
    div_val = 8'd2; div_wr = 2'b01; step();
    chk("c0_busy", int'(busy), 1);
    div_val = 8'd3; div_wr = 2'b10; step();
    chk("c1_busy", int'(busy), 2);
    div_wr = 2'b00; step();
    chk("cx_busy", int'(busy), 0);
    en = 2'b11;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("dual_clk", int'(clk_out), int'({(k % 3) == 0, (k % 2) == 0}));
      chk("dual_tick", int'(tick), int'({(k % 3) == 0, (k % 2) == 0}));
    end
    div_val = 8'd4; div_wr = 2'b10;
    for (int k = 12; k < 18; k++) begin
      step(); div_wr = 2'b00;
      chk("iso_clk0", int'(clk_out[0]), int'((k % 2) == 0));
      chk("iso_busy0", int'(busy[0]), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clkdiv_gen.md
CLKDIV_GEN -- requirements
Module: clkdiv_gen

Interface
REQ-001 Parameter NCH, default 2, number of independent divider channels.
REQ-002 Parameter DIVW, default 8, width of the divide-ratio field.
REQ-003 Parameter DIV_INIT, default 5, divide ratio loaded into every channel at reset; legal range 2..2^DIVW-1.
REQ-004 fclk  in  1  single clock for all logic, driven by the PS7 fabric clock.
REQ-005 rst  in  1  reset, synchronous to fclk and active-high.
REQ-006 en  in  NCH  per-channel run enable, level-sensitive.
REQ-007 div_wr  in  NCH  per-channel one-cycle strobe that writes div_val as that channel's new ratio.
REQ-008 div_val  in  DIVW  new divide ratio, shared by all channels and sampled on div_wr.
REQ-009 clk_out  out  NCH  divided clock, registered and glitch-free.
REQ-010 tick  out  NCH  one-fclk pulse in each cycle where clk_out goes 0->1.
REQ-011 busy  out  NCH  high while a written ratio is pending and not yet applied.

Function
REQ-012 Each channel has: counter cnt (DIVW bits), active ratio div, pending ratio pdiv, and state IDLE/RUN/STOP.
REQ-013 The high count hi is div>>1 (integer). Examples: div=5 gives hi=2; div=2 gives hi=1.
REQ-014 In RUN and STOP, clk_out=1 exactly in cycles where cnt<hi, and 0 otherwise.
REQ-015 In RUN and STOP, cnt increments by 1 per cycle and wraps from div-1 to 0.
REQ-016 Duty cycle is hi/div; odd ratios are low-biased. No negedge logic is used.
REQ-017 IDLE -> RUN: in the cycle after en=1 is sampled, cnt=0, clk_out=1 and tick=1.
REQ-018 RUN -> STOP: on en=0; the current period still completes.
REQ-019 STOP -> IDLE: at cnt=div-1; cnt then holds at 0 and clk_out holds at 0.
REQ-020 STOP -> RUN: if en=1 is seen at cnt=div-1, the channel goes straight to RUN with no gap and no truncated pulse.
REQ-021 tick=1 only in a cycle where cnt=0 and the state is RUN; it is 0 in every other cycle.
REQ-022 div_wr with div_val>=2: pdiv<=div_val and busy<=1 on the next cycle.
REQ-023 div_wr with div_val<2: ignored; pdiv, busy and div are unchanged.
REQ-024 Pending ratio in RUN/STOP: applied only at the wrap cycle (cnt=div-1). The next cycle uses div=pdiv, cnt=0 and busy=0.
REQ-025 No period is ever truncated or stretched by a ratio change.
REQ-026 Pending ratio in IDLE: applied on the cycle after the write; busy is high for exactly one cycle.
REQ-027 A div_wr while busy=1 overwrites pdiv; only the last value is applied, and busy stays high.
REQ-028 div_wr in the same cycle as a wrap: the wrap applies the old pdiv (if one was pending). The new value becomes pending and busy=1.
REQ-029 Channels are fully independent; sharing div_val creates no coupling beyond the shared data bus.
REQ-030 Outputs have no combinational path from any input.

Reset
REQ-031 On rst=1 at a fclk edge, every channel goes to: state=IDLE, cnt=0, div=pdiv=DIV_INIT, clk_out=0, tick=0, busy=0.
REQ-032 rst overrides en and div_wr in the same cycle.
REQ-033 rst during RUN forces clk_out to 0 on the next cycle, even mid-high-phase.
REQ-034 The first clean period follows the IDLE->RUN rule after rst falls.
REQ-035 Elaboration fails if DIV_INIT<2 or DIV_INIT>2^DIVW-1.

Verification
REQ-036 After reset, en[0]=1 held -> clk_out[0] = 1,1,0,0,0 repeating from the next cycle; tick[0] fires every 5 cycles, first on cycle 1.
REQ-037 div=5 running, div_wr[0] with div_val=4 at cnt=1 -> busy=1 for 4 cycles; current period finishes as 5; then clk_out[0] = 1,1,0,0 repeating; busy drops with the first cnt=0 at div=4.
REQ-038 div=5 running, en[0]=0 at cnt=1 -> clk_out continues 1 (cnt1), 0, 0, 0, then stays 0 in IDLE; tick silent; en re-raised -> pattern restarts with 1 on the next cycle.
REQ-039 div_wr[0] with div_val=1, then with div_val=0 -> busy stays 0; ratio remains 5.
REQ-040 NCH=2 with ch0 div=2 and ch1 div=3, both enabled -> ch0 = 1,0 repeating and ch1 = 1,0,0 repeating; ticks coincide every 6 cycles; writes to ch1 leave ch0 unchanged.
REQ-041 rst pulsed during a high phase -> clk_out=0, tick=0, busy=0 on the next cycle; div is back to 5.
